ra_2r1w_32x32_bist: RTL and testbench

//  Built-in self-test sequencer and port mux sitting directly upstream of ra_2r1w_32x32_sdr.

---
 rtl/ra_2r1w_32x32_bist_pkg.sv | 38 +++
 rtl/ra_2r1w_32x32_bist_cmp.sv | 85 ++++++++
 rtl/ra_2r1w_32x32_bist.sv | 181 ++++++++++++++++++
 tb/tb_ra_2r1w_32x32_bist.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ra_2r1w_32x32_bist_pkg.sv
// Shared types and defaults for the 2R1W 32x32 array BIST.
// Phase codes, background pattern, read latency, compare bundle.
package ra_2r1w_32x32_bist_pkg;

  localparam int          BIST_RD_LAT  = 2;
  localparam logic [31:0] BIST_PATTERN = 32'hA5A5_5A5A;

  localparam logic [1:0] PH_W0 = 2'd0;
  localparam logic [1:0] PH_R0 = 2'd1;
  localparam logic [1:0] PH_W1 = 2'd2;
  localparam logic [1:0] PH_R1 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_P0,
    ST_P1,
    ST_P2,
    ST_P3,
    ST_DRAIN,
    ST_DONE
  } bist_state_t;

  typedef struct packed {
    logic        vld;
    logic [4:0]  adr;
    logic [1:0]  phase;
    logic [31:0] exp;
  } cmp_req_t;

  // Address-unique background: data(a) = pattern ^ a
  function automatic logic [31:0] bist_data(
    input logic [31:0] pat,
    input logic [4:0]  a
  );
    return pat ^ {27'b0, a};
  endfunction

endpackage

// File: rtl/ra_2r1w_32x32_bist_cmp.sv
// Read-data checker: RD_LAT delay line per port, compare, first-fail
// capture and saturating miscompare count. clr wipes results only.
module ra_bist_cmp
  import ra_2r1w_32x32_bist_pkg::*;
#(
  parameter int RD_LAT = BIST_RD_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  cmp_req_t    req_0,
  input  cmp_req_t    req_1,
  input  logic [31:0] rd_dat_0,
  input  logic [31:0] rd_dat_1,
  output logic        fail,
  output logic [4:0]  fail_adr,
  output logic        fail_port,
  output logic [1:0]  fail_phase,
  output logic [7:0]  fail_cnt
);

  cmp_req_t    pipe_0 [RD_LAT];
  cmp_req_t    pipe_1 [RD_LAT];
  cmp_req_t    out_0;
  cmp_req_t    out_1;
  logic        mis_0;
  logic        mis_1;
  logic [1:0]  inc;
  logic [8:0]  sum;
  logic [7:0]  cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_0[i] <= '0;
        pipe_1[i] <= '0;
      end
    end else begin
      pipe_0[0] <= req_0;
      pipe_1[0] <= req_1;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_0[i] <= pipe_0[i-1];
        pipe_1[i] <= pipe_1[i-1];
      end
    end
  end

  assign out_0 = pipe_0[RD_LAT-1];
  assign out_1 = pipe_1[RD_LAT-1];

  assign mis_0 = out_0.vld && (rd_dat_0 != out_0.exp);
  assign mis_1 = out_1.vld && (rd_dat_1 != out_1.exp);

  assign inc     = {1'b0, mis_0} + {1'b0, mis_1};
  assign sum     = {1'b0, fail_cnt} + {7'b0, inc};
  assign cnt_nxt = sum[8] ? 8'hFF : sum[7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fail       <= 1'b0;
      fail_adr   <= '0;
      fail_port  <= 1'b0;
      fail_phase <= '0;
      fail_cnt   <= '0;
    end else if (clr) begin
      fail       <= 1'b0;
      fail_adr   <= '0;
      fail_port  <= 1'b0;
      fail_phase <= '0;
      fail_cnt   <= '0;
    end else begin
      fail_cnt <= cnt_nxt;
      if (mis_0 || mis_1) begin
        fail <= 1'b1;
        // port 0 takes priority when both miss together
        if (!fail) begin
          fail_port  <= !mis_0;
          fail_adr   <= mis_0 ? out_0.adr : out_1.adr;
          fail_phase <= mis_0 ? out_0.phase : out_1.phase;
        end
      end
    end
  end

endmodule

// File: rtl/ra_2r1w_32x32_bist.sv
// March BIST sequencer and port mux in front of ra_2r1w_32x32_sdr.
// Ports: start/busy/done/fail*, f_* functional reqs, array rd/wr ports.
module ra_2r1w_32x32_bist
  import ra_2r1w_32x32_bist_pkg::*;
#(
  parameter int          RD_LAT  = BIST_RD_LAT,
  parameter logic [31:0] PATTERN = BIST_PATTERN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [4:0]  fail_adr,
  output logic        fail_port,
  output logic [1:0]  fail_phase,
  output logic [7:0]  fail_cnt,
  input  logic        f_rd_enb_0,
  input  logic [4:0]  f_rd_adr_0,
  input  logic        f_rd_enb_1,
  input  logic [4:0]  f_rd_adr_1,
  input  logic        f_wr_enb_0,
  input  logic [4:0]  f_wr_adr_0,
  input  logic [31:0] f_wr_dat_0,
  output logic        rd_enb_0,
  output logic [4:0]  rd_adr_0,
  output logic        rd_enb_1,
  output logic [4:0]  rd_adr_1,
  output logic        wr_enb_0,
  output logic [4:0]  wr_adr_0,
  output logic [31:0] wr_dat_0,
  input  logic [31:0] rd_dat_0,
  input  logic [31:0] rd_dat_1
);

  localparam logic [4:0] DRAIN_LAST = 5'(RD_LAT - 1);

  bist_state_t state;
  logic [4:0]  cnt;
  logic        last;
  logic        accept;

  logic        b_wr_enb;
  logic [4:0]  b_wr_adr;
  logic [31:0] b_wr_dat;
  logic        b_rd_enb;
  logic [4:0]  b_rd_adr_0;
  logic [4:0]  b_rd_adr_1;
  logic [1:0]  b_phase;
  logic        b_inv;
  cmp_req_t    req_0;
  cmp_req_t    req_1;

  assign last   = (cnt == 5'd31);
  assign accept = start &&
                  (state == ST_IDLE || state == ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_P0;
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        ST_P0: begin
          cnt <= cnt + 5'd1;
          if (last) state <= ST_P1;
        end
        ST_P1: begin
          cnt <= cnt + 5'd1;
          if (last) state <= ST_P2;
        end
        ST_P2: begin
          cnt <= cnt + 5'd1;
          if (last) state <= ST_P3;
        end
        ST_P3: begin
          cnt <= cnt + 5'd1;
          if (last) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            state <= ST_DONE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Descending phases walk ~cnt so cnt always counts up
  always_comb begin
    b_wr_enb   = 1'b0;
    b_wr_adr   = cnt;
    b_wr_dat   = '0;
    b_rd_enb   = 1'b0;
    b_rd_adr_0 = cnt;
    b_phase    = PH_W0;
    b_inv      = 1'b0;
    case (state)
      ST_P0: begin
        b_wr_enb = 1'b1;
        b_wr_adr = cnt;
        b_wr_dat = bist_data(PATTERN, cnt);
      end
      ST_P1: begin
        b_rd_enb   = 1'b1;
        b_rd_adr_0 = cnt;
        b_phase    = PH_R0;
      end
      ST_P2: begin
        b_wr_enb = 1'b1;
        b_wr_adr = ~cnt;
        b_wr_dat = ~bist_data(PATTERN, ~cnt);
        b_phase  = PH_W1;
      end
      ST_P3: begin
        b_rd_enb   = 1'b1;
        b_rd_adr_0 = ~cnt;
        b_phase    = PH_R1;
        b_inv      = 1'b1;
      end
      default: ;
    endcase
  end

  // port 1 mirrors port 0: 31 - a
  assign b_rd_adr_1 = ~b_rd_adr_0;

  always_comb begin
    req_0.vld   = b_rd_enb;
    req_0.adr   = b_rd_adr_0;
    req_0.phase = b_phase;
    req_0.exp   = bist_data(PATTERN, b_rd_adr_0) ^ {32{b_inv}};
    req_1.vld   = b_rd_enb;
    req_1.adr   = b_rd_adr_1;
    req_1.phase = b_phase;
    req_1.exp   = bist_data(PATTERN, b_rd_adr_1) ^ {32{b_inv}};
  end

  ra_bist_cmp #(
    .RD_LAT (RD_LAT)
  ) u_cmp (
    .clk        (clk),
    .reset      (reset),
    .clr        (accept),
    .req_0      (req_0),
    .req_1      (req_1),
    .rd_dat_0   (rd_dat_0),
    .rd_dat_1   (rd_dat_1),
    .fail       (fail),
    .fail_adr   (fail_adr),
    .fail_port  (fail_port),
    .fail_phase (fail_phase),
    .fail_cnt   (fail_cnt)
  );

  assign rd_enb_0 = busy ? b_rd_enb   : f_rd_enb_0;
  assign rd_adr_0 = busy ? b_rd_adr_0 : f_rd_adr_0;
  assign rd_enb_1 = busy ? b_rd_enb   : f_rd_enb_1;
  assign rd_adr_1 = busy ? b_rd_adr_1 : f_rd_adr_1;
  assign wr_enb_0 = busy ? b_wr_enb   : f_wr_enb_0;
  assign wr_adr_0 = busy ? b_wr_adr   : f_wr_adr_0;
  assign wr_dat_0 = busy ? b_wr_dat   : f_wr_dat_0;

endmodule

// File: tb/tb_ra_2r1w_32x32_bist.sv
// Directed bench for ra_2r1w_32x32_bist with a 2-cycle array model.
// Fault modes: stuck bits, address alias, corrupted reads.
module tb_ra_2r1w_32x32_bist;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, fail, fail_port;
  logic [4:0]  fail_adr;
  logic [1:0]  fail_phase;
  logic [7:0]  fail_cnt;
  logic        f_rd_enb_0, f_rd_enb_1, f_wr_enb_0;
  logic [4:0]  f_rd_adr_0, f_rd_adr_1, f_wr_adr_0;
  logic [31:0] f_wr_dat_0;
  logic        rd_enb_0, rd_enb_1, wr_enb_0;
  logic [4:0]  rd_adr_0, rd_adr_1, wr_adr_0;
  logic [31:0] wr_dat_0, rd_dat_0, rd_dat_1;

  int errors = 0;
  int checks = 0;
  int mode   = 0;

  always #5 clk = ~clk;

  ra_2r1w_32x32_bist dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .fail(fail),
    .fail_adr(fail_adr), .fail_port(fail_port),
    .fail_phase(fail_phase), .fail_cnt(fail_cnt),
    .f_rd_enb_0(f_rd_enb_0), .f_rd_adr_0(f_rd_adr_0),
    .f_rd_enb_1(f_rd_enb_1), .f_rd_adr_1(f_rd_adr_1),
    .f_wr_enb_0(f_wr_enb_0), .f_wr_adr_0(f_wr_adr_0),
    .f_wr_dat_0(f_wr_dat_0),
    .rd_enb_0(rd_enb_0), .rd_adr_0(rd_adr_0),
    .rd_enb_1(rd_enb_1), .rd_adr_1(rd_adr_1),
    .wr_enb_0(wr_enb_0), .wr_adr_0(wr_adr_0),
    .wr_dat_0(wr_dat_0),
    .rd_dat_0(rd_dat_0), .rd_dat_1(rd_dat_1)
  );

  // array model: address latched, data registered one edge later
  logic [31:0] mem [32];
  logic [4:0]  ra0_q, ra1_q;
  logic [31:0] rd0_q, rd1_q;

  function automatic logic [4:0] amap(input logic [4:0] a);
    return (mode == 3 && a == 5'd9) ? 5'd8 : a;
  endfunction

  function automatic logic [31:0] mrd(input logic [4:0] a);
    logic [31:0] d;
    d = mem[amap(a)];
    if (mode == 1 && amap(a) == 5'd5) d[7] = 1'b1;
    if (mode == 2 && amap(a) == 5'd5) d[7] = 1'b0;
    if (mode == 4) d[0] = ~d[0];
    return d;
  endfunction

  always @(posedge clk) begin
    if (wr_enb_0) mem[amap(wr_adr_0)] <= wr_dat_0;
    if (rd_enb_0) ra0_q <= rd_adr_0;
    if (rd_enb_1) ra1_q <= rd_adr_1;
    rd0_q <= mrd(ra0_q);
    rd1_q <= mrd(ra1_q);
  end

  assign rd_dat_0 = rd0_q;
  assign rd_dat_1 = rd1_q;

  function automatic logic [31:0] pat(input logic [4:0] a);
    return 32'hA5A5_5A5A ^ {27'b0, a};
  endfunction

  // start high across one edge; returns at negedge of cycle 1
  task automatic launch();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
  endtask

  task automatic fread(input logic [4:0] a0, input logic [4:0] a1,
                       output logic [31:0] d0, output logic [31:0] d1);
    @(negedge clk);
    f_rd_enb_0 = 1'b1; f_rd_adr_0 = a0;
    f_rd_enb_1 = 1'b1; f_rd_adr_1 = a1;
    @(negedge clk);
    f_rd_enb_0 = 1'b0; f_rd_enb_1 = 1'b0;
    @(negedge clk);
    d0 = rd_dat_0; d1 = rd_dat_1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, fail, fail_port} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000",
               {busy, done, fail, fail_port});
    end
    checks++;
    if ({fail_adr, fail_phase, fail_cnt} !== 15'b0) begin
      errors++;
      $display("FAIL reset_info got %h want 0",
               {fail_adr, fail_phase, fail_cnt});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_march(input int m, input string nm,
                            input logic efail, input logic [4:0] eadr,
                            input logic eport, input logic [1:0] eph,
                            input logic [7:0] ecnt);
    int cyc, dc, bc;
    logic b1;
    mode = m;
    launch();
    cyc = 1; dc = -1; bc = 0; b1 = busy;
    while (cyc < 400) begin
      if (done) begin
        dc = cyc;
        break;
      end
      if (busy) bc++;
      if (cyc == 1) begin
        checks++;
        if (wr_enb_0 !== 1'b1 || wr_adr_0 !== 5'd0 ||
            wr_dat_0 !== pat(5'd0) || rd_enb_0 !== 1'b0) begin
          errors++;
          $display("FAIL %s p0_first got %b %0d %h want 1 0 %h",
                   nm, wr_enb_0, wr_adr_0, wr_dat_0, pat(5'd0));
        end
      end
      if (cyc == 33) begin
        checks++;
        if (rd_adr_0 !== 5'd0 || rd_adr_1 !== 5'd31 ||
            wr_enb_0 !== 1'b0) begin
          errors++;
          $display("FAIL %s p1_first got %0d %0d want 0 31",
                   nm, rd_adr_0, rd_adr_1);
        end
      end
      if (cyc == 65) begin
        checks++;
        if (wr_adr_0 !== 5'd31 || wr_dat_0 !== ~pat(5'd31)) begin
          errors++;
          $display("FAIL %s p2_first got %0d %h want 31 %h",
                   nm, wr_adr_0, wr_dat_0, ~pat(5'd31));
        end
      end
      if (cyc == 97) begin
        checks++;
        if (rd_adr_0 !== 5'd31 || rd_adr_1 !== 5'd0) begin
          errors++;
          $display("FAIL %s p3_first got %0d %0d want 31 0",
                   nm, rd_adr_0, rd_adr_1);
        end
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (dc != 131) begin
      errors++;
      $display("FAIL %s done_cycle got %0d want 131", nm, dc);
    end
    checks++;
    if (bc != 130 || b1 !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy got cnt=%0d c1=%b end=%b want 130 1 0",
               nm, bc, b1, busy);
    end
    checks++;
    if (fail !== efail || fail_adr !== eadr ||
        fail_port !== eport || fail_phase !== eph) begin
      errors++;
      $display("FAIL %s info got %b %0d %b %0d want %b %0d %b %0d",
               nm, fail, fail_adr, fail_port, fail_phase,
               efail, eadr, eport, eph);
    end
    checks++;
    if (fail_cnt !== ecnt) begin
      errors++;
      $display("FAIL %s fail_cnt got %0d want %0d", nm, fail_cnt, ecnt);
    end
  endtask

  task automatic test_clear_on_start();
    mode = 0;
    launch();
    checks++;
    if (fail !== 1'b0 || fail_cnt !== 8'd0 || done !== 1'b0 ||
        fail_adr !== 5'd0 || fail_phase !== 2'd0) begin
      errors++;
      $display("FAIL clear got f=%b c=%0d d=%b a=%0d p=%0d want 0",
               fail, fail_cnt, done, fail_adr, fail_phase);
    end
    for (int i = 0; i < 400 && !done; i++) @(negedge clk);
    checks++;
    if (done !== 1'b1 || fail !== 1'b0) begin
      errors++;
      $display("FAIL clear_run got d=%b f=%b want 1 0", done, fail);
    end
  endtask

  task automatic test_passthrough();
    logic [31:0] d0, d1;
    mode = 0;
    @(negedge clk);
    f_wr_enb_0 = 1'b1; f_wr_adr_0 = 5'd3; f_wr_dat_0 = 32'h1234_5678;
    @(negedge clk);
    f_wr_enb_0 = 1'b0;
    fread(5'd3, 5'd4, d0, d1);
    checks++;
    if (d0 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL pass_rd0 got %h want 12345678", d0);
    end
    checks++;
    if (d1 !== ~pat(5'd4)) begin
      errors++;
      $display("FAIL pass_rd1 got %h want %h", d1, ~pat(5'd4));
    end
  endtask

  task automatic test_busy_isolation();
    logic [31:0] d0, d1;
    int cyc;
    mode = 0;
    launch();
    cyc = 1;
    while (cyc < 400 && !done) begin
      f_wr_enb_0 = 1'b1;
      f_wr_adr_0 = 5'($urandom_range(0, 31));
      f_wr_dat_0 = $urandom;
      f_rd_enb_0 = 1'($urandom);
      f_rd_adr_0 = 5'($urandom_range(0, 31));
      @(negedge clk);
      cyc++;
    end
    f_wr_enb_0 = 1'b0; f_rd_enb_0 = 1'b0;
    checks++;
    if (done !== 1'b1 || fail !== 1'b0 || cyc != 131) begin
      errors++;
      $display("FAIL iso_run got d=%b f=%b cyc=%0d want 1 0 131",
               done, fail, cyc);
    end
    fread(5'd3, 5'd17, d0, d1);
    checks++;
    if (d0 !== ~pat(5'd3) || d1 !== ~pat(5'd17)) begin
      errors++;
      $display("FAIL iso_mem got %h %h want %h %h",
               d0, d1, ~pat(5'd3), ~pat(5'd17));
    end
  endtask

  task automatic test_reset_mid();
    mode = 4;
    launch();
    repeat (49) @(negedge clk);
    checks++;
    if (fail !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got f=%b b=%b want 1 1", fail, busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, fail} !== 3'b0 || fail_cnt !== 8'd0) begin
      errors++;
      $display("FAIL async_reset got %b cnt=%0d want 000 0",
               {busy, done, fail}, fail_cnt);
    end
    @(negedge clk) reset = 1'b0;
    repeat (8) @(negedge clk);
    test_march(0, "post_reset", 1'b0, 5'd0, 1'b0, 2'd0, 8'd0);
  endtask

  task automatic test_start_held();
    int cyc, dn, first, dc;
    logic b132;
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc = 1; dn = 0; first = -1; dc = -1; b132 = 1'b0;
    while (cyc <= 200) begin
      if (done) begin
        dn++;
        if (first < 0) first = cyc;
      end
      if (cyc == 132) b132 = busy;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    while (cyc < 600) begin
      if (done) begin
        dc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (dn != 1 || first != 131 || b132 !== 1'b1) begin
      errors++;
      $display("FAIL held_restart got n=%0d at=%0d b=%b want 1 131 1",
               dn, first, b132);
    end
    checks++;
    if (dc != 262) begin
      errors++;
      $display("FAIL held_second got %0d want 262", dc);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL held_hold got d=%b b=%b want 1 0", done, busy);
    end
  endtask

  task automatic test_start_ignore();
    int cyc;
    mode = 0;
    launch();
    cyc = 1;
    while (cyc < 400 && !done) begin
      start = (cyc == 40 || cyc == 70 || cyc == 130);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (cyc != 131) begin
      errors++;
      $display("FAIL ignore_done got %0d want 131", cyc);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL ignore_restart got b=%b d=%b want 0 1", busy, done);
    end
  endtask

  initial begin
    start = 1'b0;
    f_rd_enb_0 = 1'b0; f_rd_adr_0 = '0;
    f_rd_enb_1 = 1'b0; f_rd_adr_1 = '0;
    f_wr_enb_0 = 1'b0; f_wr_adr_0 = '0; f_wr_dat_0 = '0;
    test_reset();
    test_march(0, "good", 1'b0, 5'd0, 1'b0, 2'd0, 8'd0);
    test_passthrough();
    test_march(1, "stuck1", 1'b1, 5'd5, 1'b0, 2'd1, 8'd2);
    test_march(2, "stuck0", 1'b1, 5'd5, 1'b1, 2'd3, 8'd2);
    test_march(3, "alias_a", 1'b1, 5'd8, 1'b0, 2'd1, 8'd4);
    test_march(3, "alias_b", 1'b1, 5'd8, 1'b0, 2'd1, 8'd4);
    test_march(4, "allbad", 1'b1, 5'd0, 1'b0, 2'd1, 8'd128);
    test_clear_on_start();
    test_busy_isolation();
    test_reset_mid();
    test_start_held();
    test_start_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
